seq_tx: RTL and testbench
=========================

# seq_tx

Serial frame transmitter that produces the bit stream consumed by the team's "101" sequence detector. The block accepts a parallel word through a valid/ready handshake and serializes it onto a single line `x` as a frame: sync pattern 1-0-1, data bits LSB first, optional even parity, then one stop bit of 0. The line idles low, so the detector sits in its reset state between frames and sees the sync pattern at the head of each frame. It sits on the transmit side of the serial link, directly driving the detector's `x` input in loopback and system benches.

## Interface
- `DATA_W`, 8, payload width in bits (≥1)
- `CLKS_PER_BIT`, 4, clock cycles each serial bit is held (≥1)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `data_in`  in  DATA_W  word to transmit, sampled on accept
- `valid`  in  1  `data_in` is valid
- `ready`  out  1  transmitter idle, can accept a word
- `x`  out  1  serial output line, registered
- `busy`  out  1  frame in progress (= !ready)
- `done`  out  1  one-cycle pulse when a frame completes

## Operation
- States: IDLE, SYNC, DATA, PAR (only with parity), STOP.
- IDLE: `ready`=1, `x`=0. Accept when `valid`&&`ready` at a rising edge. `data_in` is latched into a shift register, the state goes to SYNC, and the bit index is cleared.
- SYNC: emits bits 1, 0, 1 in order, then moves to DATA.
- DATA: emits the shift register LSB first for DATA_W bits. The register shifts right once per bit. Next state is PAR if parity is enabled, otherwise STOP.
- PAR: emits the XOR of all latched data bits, so the total number of 1s across data and parity is even. Then moves to STOP.
- STOP: emits 0 for one bit, then returns to IDLE with `done`=1 for exactly one cycle.
- Each bit is held CLKS_PER_BIT cycles. A cycle counter of width clog2(CLKS_PER_BIT), minimum 1 bit, counts 0..CLKS_PER_BIT-1 and advances the bit on terminal count. The bit-index counter is sized for max(3, DATA_W).
- `valid` outside IDLE is ignored. `data_in` changes after accept do not affect the frame in flight.
- `ready` and `busy` are decoded from the registered state, with no combinational path from `valid`.
- Frame length: 3 + DATA_W + P + 1 bits, where P=1 with parity and 0 without. It lasts that bit count × CLKS_PER_BIT cycles.

## Timing
- Reset (async assert): state IDLE, `x`=0, `ready`=1, `busy`=0, `done`=0, counters 0, shift register 0. Takes effect mid-frame immediately and the frame is abandoned. After release, the first accept can occur on the first rising edge.
- Accept at edge k: `x`=1 (first sync bit) from edge k for CLKS_PER_BIT cycles, and `ready`=0 from edge k.
- Last STOP cycle ends at edge k + L×CLKS_PER_BIT, where L is the frame length in bits. At that edge `ready`=1 and `done`=1 for one cycle.
- Back-to-back: if `valid` is high while `done`=1, the word is accepted at the next edge. Minimum spacing between frames is then one idle cycle of `x`=0 after the stop bit.
- With CLKS_PER_BIT=1, every bit lasts exactly one cycle.

## Configuration
- `SEQ_TX_PARITY_EN` defined: PAR state and the parity bit are present, and the frame is DATA_W+5 bits.
- `SEQ_TX_PARITY_EN` undefined: the PAR state and parity logic are compiled out, DATA goes directly to STOP, and the frame is DATA_W+4 bits.

## Test plan
- CLKS_PER_BIT=1, no parity, send 0xA5 → `x` after accept = 1,0,1, 1,0,1,0,0,1,0,1, 0. `done` pulses 12 cycles after accept.
- CLKS_PER_BIT=4, parity on, send 0x07 → each bit held 4 cycles, parity bit=1, frame = 13 bits = 52 cycles, `ready` low throughout.
- `valid` held high continuously, words 0x01 then 0xFF → second frame starts the edge after `done`, exactly one idle-low cycle between frames, and both payloads are correct.
- Change `data_in` and pulse `valid` mid-frame → `x` stream unchanged, no extra accept, single `done`.
- Assert `rst_n` low during DATA bit 3 → `x`=0 and `ready`=1 asynchronously. After release, a new word 0x3C transmits cleanly.
- Loopback into the sequence detector with 0x00, no parity, CLKS_PER_BIT=1 → detector `y`=1 for exactly one cycle, starting the cycle after the third sync bit is sampled. No further `y` assertions occur during the zero payload and stop bit.

Source files
------------

// File: rtl/seq_tx.sv
// Serial frame transmitter: sync 1-0-1, DATA_W bits LSB first, optional even parity, stop 0.
// Optional parity bit is enabled by defining SEQ_TX_PARITY_EN.
module seq_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              x,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_MAX = (DATA_W > 3) ? DATA_W : 3;
  localparam int IDX_W   = $clog2(IDX_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STOP
`ifdef SEQ_TX_PARITY_EN
    , S_PAR
`endif
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              x_q;
  logic              done_q;
  logic              bit_end;
`ifdef SEQ_TX_PARITY_EN
  logic              par_q;
`endif

  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign shift_d = shift_q >> 1;

  // x_q always holds the bit currently on the line; it is loaded with the
  // next bit on the edge that ends the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      x_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            shift_q <= data_in;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= ^data_in;
`endif
            state_q <= S_SYNC;
            idx_q   <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b1;
          end
        end
        S_SYNC: begin
          if (bit_end) begin
            if (idx_q == IDX_W'(2)) begin
              state_q <= S_DATA;
              idx_q   <= '0;
              x_q     <= shift_q[0];
            end else begin
              idx_q <= idx_q + 1'b1;
              x_q   <= idx_q[0];
            end
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift_q <= shift_d;
            if (idx_q == IDX_W'(DATA_W - 1)) begin
              idx_q <= '0;
`ifdef SEQ_TX_PARITY_EN
              state_q <= S_PAR;
              x_q     <= par_q;
`else
              state_q <= S_STOP;
              x_q     <= 1'b0;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
              x_q   <= shift_d[0];
            end
          end
        end
`ifdef SEQ_TX_PARITY_EN
        S_PAR: begin
          if (bit_end) begin
            state_q <= S_STOP;
            x_q     <= 1'b0;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            x_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          x_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = ~ready;
  assign x     = x_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx: two instances (1 and 4 clocks per bit) checked cycle by cycle.
module tb_seq_tx;

  localparam int DW = 8;
`ifdef SEQ_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = DW + 4 + P;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] d1, d4;
  logic          v1, v4;
  logic          r1, x1, b1, dn1;
  logic          r4, x4, b4, dn4;

  always #5 clk = ~clk;

  seq_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(d1), .valid(v1),
    .ready(r1), .x(x1), .busy(b1), .done(dn1)
  );
  seq_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .data_in(d4), .valid(v4),
    .ready(r4), .x(x4), .busy(b4), .done(dn4)
  );

  typedef struct packed { logic x; logic rdy; logic dn; } exp_t;
  exp_t q[2][$];
  int   rem1 = 0, rem4 = 0;
  int   acc1 = 0, acc4 = 0;
  int   checks = 0, errors = 0;
  int   dcnt4 = 0, ycnt = 0;
  logic [2:0] sh = 3'b000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_frame(input int u, input logic [DW-1:0] d, input int cpb);
    logic bits[$];
    exp_t e;
    bits = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (P == 1) bits.push_back(^d);
    bits.push_back(1'b0);
    foreach (bits[i]) begin
      for (int c = 0; c < cpb; c++) begin
        e = '{x: bits[i], rdy: 1'b0, dn: 1'b0};
        q[u].push_back(e);
      end
    end
    e = '{x: 1'b0, rdy: 1'b1, dn: 1'b1};
    q[u].push_back(e);
  endfunction

  // Reference model of acceptance timing: a frame occupies L*cpb edges.
  always @(posedge clk) begin
    if (!rst_n) rem1 = 0;
    else if (rem1 == 0 && v1) begin
      push_frame(0, d1, 1); rem1 = L; acc1++;
      $display("accept u1 data=%02h", d1);
    end else if (rem1 > 0) rem1--;
  end
  always @(posedge clk) begin
    if (!rst_n) rem4 = 0;
    else if (rem4 == 0 && v4) begin
      push_frame(1, d4, 4); rem4 = L * 4; acc4++;
      $display("accept u4 data=%02h", d4);
    end else if (rem4 > 0) rem4--;
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    e = (q[0].size() > 0) ? q[0].pop_front() : '{x: 1'b0, rdy: 1'b1, dn: 1'b0};
    check("u1_cycle", {28'd0, x1, r1, b1, dn1}, {28'd0, e.x, e.rdy, ~e.rdy, e.dn});
    e = (q[1].size() > 0) ? q[1].pop_front() : '{x: 1'b0, rdy: 1'b1, dn: 1'b0};
    check("u4_cycle", {28'd0, x4, r4, b4, dn4}, {28'd0, e.x, e.rdy, ~e.rdy, e.dn});
  end

  always @(posedge clk) begin
    if (dn4) dcnt4 <= dcnt4 + 1;
    sh <= {sh[1:0], x1};
  end
  // Behavioural "101" detector fed from u1 in loopback.
  always @(posedge clk) if (sh == 3'b101) ycnt <= ycnt + 1;

  task automatic send1(input logic [DW-1:0] d);
    @(negedge clk); d1 = d; v1 = 1'b1;
    @(negedge clk); v1 = 1'b0;
    repeat (L + 3) @(negedge clk);
  endtask

  task automatic send4(input logic [DW-1:0] d);
    @(negedge clk); d4 = d; v4 = 1'b1;
    @(negedge clk); v4 = 1'b0;
    repeat (L * 4 + 3) @(negedge clk);
  endtask

  initial begin
    int base, dbase, ybase;
    d1 = '0; d4 = '0; v1 = 1'b0; v4 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_u1", {28'd0, x1, r1, b1, dn1}, 32'h4);
    check("reset_u4", {28'd0, x4, r4, b4, dn4}, 32'h4);
    rst_n = 1'b1;

    send1(8'hA5);
    send4(8'h07);
    send1(8'h3C);

    // valid held high across two frames
    @(negedge clk); d1 = 8'h01; v1 = 1'b1; base = acc1;
    for (int i = 0; i < 4 * L && acc1 < base + 2; i++) begin
      @(negedge clk);
      if (acc1 == base + 1) d1 = 8'hFF;
    end
    v1 = 1'b0;
    check("b2b_accepts", acc1, base + 2);
    repeat (L + 3) @(negedge clk);

    // data/valid disturbance mid-frame
    dbase = dcnt4;
    @(negedge clk); d4 = 8'h5A; v4 = 1'b1;
    @(negedge clk); v4 = 1'b0;
    repeat (10) @(negedge clk);
    d4 = 8'hFF; v4 = 1'b1;
    repeat (2) @(negedge clk);
    v4 = 1'b0; d4 = 8'h00;
    repeat (L * 4) @(negedge clk);
    check("single_done", dcnt4 - dbase, 1);

    // async reset during DATA bit 3 (line high since bit 3 of 0xF8 is 1)
    @(negedge clk); d4 = 8'hF8; v4 = 1'b1;
    @(negedge clk); v4 = 1'b0;
    repeat (25) @(negedge clk);
    check("pre_reset_x", {31'd0, x4}, 32'd1);
    #2 rst_n = 1'b0;
    q[0].delete(); q[1].delete();
    #1;
    check("async_reset", {28'd0, x4, r4, b4, dn4}, 32'h4);
    @(negedge clk);
    rst_n = 1'b1; d4 = 8'h3C; v4 = 1'b1;
    @(negedge clk); v4 = 1'b0;
    repeat (L * 4 + 3) @(negedge clk);

    // loopback into detector: zero payload
    ybase = ycnt;
    send1(8'h00);
    check("detector_y", ycnt - ybase, 1);

    send4(8'hC3);
    check("u1_queue_empty", q[0].size(), 0);
    check("u4_queue_empty", q[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
